// File: rtl/stutter_sched_pkg.sv
// Shared types and constants for the stutter scheduler.
// Optional feature macro: STUTTER_SCHED_TRACE_EN (total-stutter counter).
package stutter_sched_pkg;

  // Scheduler phases. dbg_state carries this encoding out of the top.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FORCE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Cycles after reset release before the echo checker is trusted.
  localparam int ARM_CYCLES = 2;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/stutter_budget.sv
// Fairness budget: counts consecutive granted stutters and the forced
// progress window that follows an exhausted budget.
// Optional feature macro: STUTTER_SCHED_TRACE_EN (not used in this file).
module stutter_budget
  import stutter_sched_pkg::*;
#(
  parameter int MAX_STUTTER  = 4,
  parameter int MIN_PROGRESS = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,        // stutter requested while the FSM is in RUN
  input  logic i_in_force,   // FSM is inside the forced-progress window
  input  logic i_clear,      // drop all budget state (IDLE, DONE, terminating)
  output logic o_grant,      // stutter may be granted this cycle
  output logic o_force,      // budget spent and a multi-cycle window is needed
  output logic o_force_last  // final cycle of the forced-progress window
);

  localparam int RUN_W = cnt_w(MAX_STUTTER);
  localparam int FRC_W = cnt_w(MIN_PROGRESS - 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_STUTTER);
  localparam logic [FRC_W-1:0] FRC_INIT = FRC_W'(MIN_PROGRESS - 1);
  localparam logic [FRC_W-1:0] FRC_ONE  = FRC_W'(1);

  logic [RUN_W-1:0] r_run_cnt;
  logic [FRC_W-1:0] r_force_cnt;
  logic             w_exhaust;

  // run_cnt never exceeds RUN_MAX: it is cleared on the exhausting request.
  assign w_exhaust    = i_req && (r_run_cnt == RUN_MAX);
  assign o_grant      = i_req && (r_run_cnt < RUN_MAX);
  assign o_force      = w_exhaust && (MIN_PROGRESS > 1);
  assign o_force_last = (r_force_cnt <= FRC_ONE);

  // Budget counters: count grants, reload the progress window on exhaustion.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_run_cnt   <= '0;
      r_force_cnt <= '0;
    end else if (i_in_force) begin
      r_run_cnt <= '0;
      if (r_force_cnt != '0) r_force_cnt <= r_force_cnt - 1'b1;
    end else if (i_req) begin
      if (w_exhaust) begin
        r_run_cnt   <= '0;
        r_force_cnt <= FRC_INIT;
      end else begin
        r_run_cnt <= r_run_cnt + 1'b1;
      end
    end else begin
      r_run_cnt <= '0;
    end
  end

endmodule

// File: rtl/stutter_scheduler.sv
// Stutter scheduler: forwards the checker's stutter choice to a codeblock
// under a fairness bound, compresses a/b into change events and checks the
// codeblock's stutter echo.
// Optional feature macro: STUTTER_SCHED_TRACE_EN adds the stutter_total port.
//
// obs_valid is a one-cycle pulse with no ready/backpressure: the consumer
// must take obs_a/obs_b on the cycle obs_valid is high; the values then stay
// stable until the next pulse.
module stutter_scheduler
  import stutter_sched_pkg::*;
#(
  parameter int MAX_STUTTER  = 4,
  parameter int MIN_PROGRESS = 1
`ifdef STUTTER_SCHED_TRACE_EN
  , parameter int TOT_W      = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stutter_req,
  input  logic             target_done,
  input  logic             stutter_echo,
  input  logic             a_in,
  input  logic             b_in,
  output logic             stutter_o,
  output logic             obs_valid,
  output logic             obs_a,
  output logic             obs_b,
  output logic             done_o,
  output logic             err,
`ifdef STUTTER_SCHED_TRACE_EN
  output logic [TOT_W-1:0] stutter_total,
`endif
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] ARM_MAX = 2'(ARM_CYCLES);

  state_t     r_state;
  state_t     w_state_next;
  logic       r_stutter_o;
  logic       w_stutter_next;
  logic       r_done;
  logic       r_err;
  logic       r_obs_valid;
  logic       r_obs_a;
  logic       r_obs_b;
  logic       r_stutter_d1;
  logic [1:0] r_arm;
  logic       w_armed;
  logic       w_grant;
  logic       w_force;
  logic       w_force_last;
  logic       w_budget_req;
  logic       w_budget_in_force;
  logic       w_budget_clear;

  assign w_budget_req      = (r_state == RUN) && stutter_req;
  assign w_budget_in_force = (r_state == FORCE);
  assign w_budget_clear    = (r_state == IDLE) || (r_state == DONE) || target_done;

  stutter_budget #(
    .MAX_STUTTER (MAX_STUTTER),
    .MIN_PROGRESS(MIN_PROGRESS)
  ) u_budget (
    .clk         (clk),
    .rst         (rst),
    .i_req       (w_budget_req),
    .i_in_force  (w_budget_in_force),
    .i_clear     (w_budget_clear),
    .o_grant     (w_grant),
    .o_force     (w_force),
    .o_force_last(w_force_last)
  );

  // Next state and next stutter_o; termination outranks budget and FORCE.
  always_comb begin
    w_state_next   = r_state;
    w_stutter_next = r_stutter_o;
    case (r_state)
      IDLE: begin
        w_state_next   = RUN;
        w_stutter_next = 1'b1;
      end
      RUN: begin
        if (target_done) begin
          w_state_next   = DONE;
          w_stutter_next = stutter_req;
        end else if (w_grant) begin
          w_stutter_next = 1'b1;
        end else begin
          w_stutter_next = 1'b0;
          if (w_force) w_state_next = FORCE;
        end
      end
      FORCE: begin
        if (target_done) begin
          w_state_next   = DONE;
          w_stutter_next = stutter_req;
        end else begin
          w_stutter_next = 1'b0;
          if (w_force_last) w_state_next = RUN;
        end
      end
      DONE: begin
        w_stutter_next = stutter_req;
      end
      default: begin
        w_state_next   = IDLE;
        w_stutter_next = 1'b1;
      end
    endcase
  end

  // FSM state, registered stutter output and sticky termination flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_stutter_o <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_stutter_o <= w_stutter_next;
      if (w_state_next == DONE) r_done <= 1'b1;
    end
  end

  // Change-event capture: only non-stutter cycles with a new (a,b) count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_obs_valid <= 1'b0;
      r_obs_a     <= 1'b0;
      r_obs_b     <= 1'b0;
    end else if (!stutter_echo && ({a_in, b_in} != {r_obs_a, r_obs_b})) begin
      r_obs_valid <= 1'b1;
      r_obs_a     <= a_in;
      r_obs_b     <= b_in;
    end else begin
      r_obs_valid <= 1'b0;
    end
  end

  assign w_armed = (r_arm == ARM_MAX);

  // Echo checker: compare the codeblock echo with stutter_o one cycle late.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stutter_d1 <= 1'b1;
      r_arm        <= '0;
      r_err        <= 1'b0;
    end else begin
      r_stutter_d1 <= r_stutter_o;
      if (!w_armed) r_arm <= r_arm + 1'b1;
      if (w_armed && (stutter_echo != r_stutter_d1)) r_err <= 1'b1;
    end
  end

`ifdef STUTTER_SCHED_TRACE_EN
  localparam logic [TOT_W-1:0] TOT_MAX = {TOT_W{1'b1}};
  logic [TOT_W-1:0] r_total;

  // Saturating count of cycles the codeblock was told to stutter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_total <= '0;
    end else if ((r_state != IDLE) && r_stutter_o && (r_total != TOT_MAX)) begin
      r_total <= r_total + 1'b1;
    end
  end

  assign stutter_total = r_total;
`endif

  assign stutter_o = r_stutter_o;
  assign obs_valid = r_obs_valid;
  assign obs_a     = r_obs_a;
  assign obs_b     = r_obs_b;
  assign done_o    = r_done;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule
